// File: rtl/ddcb_tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ddcb_tap_pkg
//  Purpose : Shared types and helpers for the multi-channel DCDL tap
//            controller: update-policy and VTC-state enums, and the
//            single-tap step function (increment/decrement with
//            wrap or saturate).
//  Ports   : none (package)
//  Rev     : 1.0  initial multi-channel release
// ============================================================================
package ddcb_tap_pkg;

    // Internal tap arithmetic is done at this fixed width. Narrower taps are
    // zero-extended; the upper bits stay zero and are trimmed in synthesis.
    localparam int TAP_W_MAX = 16;

    typedef logic [TAP_W_MAX-1:0] tap_t;

    typedef enum logic [1:0] {
        UPD_IMM    = 2'd0,
        UPD_MANUAL = 2'd1,
        UPD_SLEW   = 2'd2
    } upd_mode_e;

    typedef enum logic [1:0] {
        VTC_ON = 2'd0,
        SETTLE = 2'd1,
        READY  = 2'd2,
        HOLD   = 2'd3
    } vtc_state_e;

    // One tap step toward inc/dec. At a bound it either wraps to the
    // opposite bound or holds, depending on wrap.
    function automatic tap_t tap_step(
        input tap_t cur,
        input logic inc,
        input logic wrap,
        input tap_t max
    );
        tap_t r;
        if (inc) begin
            if (cur == max) r = wrap ? '0 : max;
            else            r = cur + tap_t'(1);
        end else begin
            if (cur == '0)  r = wrap ? max : '0;
            else            r = cur - tap_t'(1);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddcb_tap_chan.sv
`default_nettype none
// ============================================================================
//  Module  : ddcb_tap_chan
//  Purpose : One delay-line channel: shadow tap (CE/INC/LOAD), active tap
//            (mux select) updated by the selected policy, pending flag and
//            optional sticky error.
//  Ports   : clk_in/rst_in  clock, async active-high reset
//            i_rdy          commands accepted this cycle
//            i_ce/i_inc/i_load/i_val  channel command
//            i_commit       manual-mode copy shadow -> active
//            o_shadow       shadow tap
//            o_active       active tap
//            o_busy         active != shadow
//            o_err          sticky error (zero unless DDCB_TAP_CTRL_ERR_EN)
//  Config  : DDCB_TAP_CTRL_ERR_EN enables the sticky error register.
//  Rev     : 1.0  initial multi-channel release
// ============================================================================
module ddcb_tap_chan
    import ddcb_tap_pkg::*;
#(
    parameter int        TAP_W    = 9,
    parameter int        DEF_TAP  = 0,
    parameter int        WRAP     = 0,
    parameter upd_mode_e UPD_MODE = UPD_IMM
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_rdy,
    input  logic             i_ce,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [TAP_W-1:0] i_val,
    input  logic             i_commit,
    output logic [TAP_W-1:0] o_shadow,
    output logic [TAP_W-1:0] o_active,
    output logic             o_busy,
    output logic             o_err
);

    localparam tap_t C_MAX  = tap_t'((1 << TAP_W) - 1);
    localparam tap_t C_DEF  = tap_t'(DEF_TAP);
    localparam logic C_WRAP = (WRAP != 0);

    tap_t r_shadow;
    tap_t r_active;
    logic r_busy;

    tap_t w_load_val;
    tap_t w_shadow_nxt;
    tap_t w_active_nxt;
    logic w_busy_nxt;
    logic w_cmd;

    always_comb begin
        w_cmd      = i_ce & i_rdy;
        w_load_val = '0;
        w_load_val[TAP_W-1:0] = i_val;

        // load has priority; inc is ignored when loading
        w_shadow_nxt = r_shadow;
        if (w_cmd) begin
            if (i_load) w_shadow_nxt = w_load_val;
            else        w_shadow_nxt = tap_step(r_shadow, i_inc, C_WRAP, C_MAX);
        end

        w_active_nxt = r_active;
        case (UPD_MODE)
            // Commit takes the pre-update shadow; a command in the same
            // cycle stays pending until the next commit.
            UPD_MANUAL: begin
                if (i_commit) w_active_nxt = r_shadow;
            end
            // Walk linearly toward the current shadow, never wrapping, so a
            // retarget mid-walk simply changes direction from where we are.
            UPD_SLEW: begin
                if (r_active < r_shadow)      w_active_nxt = r_active + tap_t'(1);
                else if (r_active > r_shadow) w_active_nxt = r_active - tap_t'(1);
            end
            default: begin
                w_active_nxt = w_shadow_nxt;
            end
        endcase

        // Registered version of (active != shadow) computed from next values
        // so busy_o is exact in the cycle the taps differ.
        w_busy_nxt = (UPD_MODE != UPD_IMM) && (w_active_nxt != w_shadow_nxt);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_shadow <= C_DEF;
            r_active <= C_DEF;
            r_busy   <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_active <= w_active_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign o_shadow = r_shadow[TAP_W-1:0];
    assign o_active = r_active[TAP_W-1:0];
    assign o_busy   = r_busy;

`ifdef DDCB_TAP_CTRL_ERR_EN
    logic r_err;
    logic w_err_set;

    // Dropped command, or a saturating step that hit a bound.
    assign w_err_set = (i_ce & ~i_rdy)
                     | (w_cmd & ~i_load & ~C_WRAP &
                        ((i_inc & (r_shadow == C_MAX)) | (~i_inc & (r_shadow == '0))));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_err <= 1'b0;
        else        r_err <= r_err | w_err_set;
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/ddcb_tap_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module  : ddcb_tap_ctrl_mc
//  Purpose : Multi-channel tap controller for DCDL delay lines. Holds the
//            VTC hold/release FSM and settle counter, and one ddcb_tap_chan
//            per channel (shadow/active taps, update policy, wrap/saturate).
//  Ports   : clk_in, rst_in (async, active-high)
//            en_vtc            1: VT compensation owns taps, commands blocked
//            ce/inc/load       per-channel command [NCH]
//            cntvaluein        load values, ch0 in LSBs [NCH*TAP_W]
//            commit            manual-mode commit of all shadows
//            cntvalueout       shadow taps [NCH*TAP_W]
//            tap_sel           active taps to delay-line mux [NCH*TAP_W]
//            busy_o            active != shadow per channel [NCH]
//            rdy_o             commands accepted
//            err_o             sticky errors per channel [NCH]
//  Config  : DDCB_TAP_CTRL_ERR_EN -- when defined, err_o flags dropped
//            commands and saturating bound hits; otherwise err_o is zero.
//  Rev     : 1.0  initial multi-channel release
// ============================================================================
module ddcb_tap_ctrl_mc
    import ddcb_tap_pkg::*;
#(
    parameter int        NCH        = 4,
    parameter int        TAP_W      = 9,
    parameter int        DEF_TAP    = 0,
    parameter int        WRAP       = 0,
    parameter upd_mode_e UPD_MODE   = UPD_IMM,
    parameter int        VTC_SETTLE = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en_vtc,
    input  logic [NCH-1:0]       ce,
    input  logic [NCH-1:0]       inc,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*TAP_W-1:0] cntvaluein,
    input  logic                 commit,
    output logic [NCH*TAP_W-1:0] cntvalueout,
    output logic [NCH*TAP_W-1:0] tap_sel,
    output logic [NCH-1:0]       busy_o,
    output logic                 rdy_o,
    output logic [NCH-1:0]       err_o
);

    localparam int                CNT_W         = $clog2(VTC_SETTLE + 1);
    localparam logic [CNT_W-1:0]  C_SETTLE_INIT = CNT_W'(VTC_SETTLE - 1);

    vtc_state_e       r_state;
    vtc_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_rdy;
    logic             w_commit;
    logic [NCH-1:0]   w_busy;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= VTC_ON;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdy   <= (w_state_nxt == READY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            VTC_ON: begin
                if (!en_vtc) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = C_SETTLE_INIT;
                end
            end
            SETTLE: begin
                if (en_vtc)              w_state_nxt = VTC_ON;
                else if (r_cnt == '0)    w_state_nxt = READY;
                else                     w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            READY: begin
                if (en_vtc) w_state_nxt = HOLD;
            end
            HOLD: begin
                // VTC may only take over once every delay line sits at its target
                if (~|w_busy) w_state_nxt = VTC_ON;
            end
            default: begin
                w_state_nxt = VTC_ON;
            end
        endcase

        // While holding, keep committing so manual-mode pending shadows drain
        // (including any command accepted in the READY->HOLD cycle).
        w_commit = commit | (r_state == HOLD);
    end

    assign rdy_o = r_rdy;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        ddcb_tap_chan #(
            .TAP_W    (TAP_W),
            .DEF_TAP  (DEF_TAP),
            .WRAP     (WRAP),
            .UPD_MODE (UPD_MODE)
        ) u_chan (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .i_rdy    (r_rdy),
            .i_ce     (ce[g]),
            .i_inc    (inc[g]),
            .i_load   (load[g]),
            .i_val    (cntvaluein[g*TAP_W +: TAP_W]),
            .i_commit (w_commit),
            .o_shadow (cntvalueout[g*TAP_W +: TAP_W]),
            .o_active (tap_sel[g*TAP_W +: TAP_W]),
            .o_busy   (w_busy[g]),
            .o_err    (err_o[g])
        );
    end

    assign busy_o = w_busy;

endmodule
`default_nettype wire
